// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake and registered results.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 1011).
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic [2*WIDTH-1:0] product,
  output logic               cout,
  output logic               of,
  output logic               zero,
  output logic               slt
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             of_q;
  logic             zero_q;
  logic             slt_q;

  logic [WIDTH-1:0] res_d;
  logic             cout_d;
  logic             of_d;
  logic             slt_d;
  logic             is_sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [SW-1:0]    rot;
  logic [SW-1:0]    nrot;

  // nrot = (WIDTH - rot) mod WIDTH, so rot==0 degenerates to a|a
  always_comb begin
    is_sub = (op == 4'b1010);
    bx     = is_sub ? ~b : b;
    sum    = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    rot    = b[SW-1:0];
    nrot   = '0 - rot;
    res_d  = '0;
    cout_d = 1'b0;
    of_d   = 1'b0;
    slt_d  = 1'b0;
    case (op)
      4'b0000: res_d = ~a;
      4'b0001: res_d = a & b;
      4'b0010: res_d = a | b;
      4'b0011: res_d = a << b;
      4'b0100: res_d = a >> b;
      4'b0101: res_d = {a[WIDTH-1], a[WIDTH-2:0] << b};
      4'b0110: res_d = $signed(a) >>> b;
      4'b0111: res_d = (a << rot) | (a >> nrot);
      4'b1000: res_d = (a >> rot) | (a << nrot);
      4'b1001, 4'b1010: begin
        res_d  = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        of_d   = (a[WIDTH-1] == bx[WIDTH-1]) &&
                 (sum[WIDTH-1] != a[WIDTH-1]);
        slt_d  = is_sub & (sum[WIDTH-1] ^ of_d);
      end
      default: res_d = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] product_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_q;
  logic [SW-1:0]      cnt_q;

  assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign product  = product_q;
`else
  assign product  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      of_q        <= 1'b0;
      zero_q      <= 1'b0;
      slt_q       <= 1'b0;
`ifdef ALU_MUL_EN
      product_q   <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
`ifdef ALU_MUL_EN
            if (op == 4'b1011) begin
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
              acc_q    <= '0;
              cnt_q    <= '0;
              state_q  <= S_MUL;
            end else
`endif
            begin
              result_q    <= res_d;
              cout_q      <= cout_d;
              of_q        <= of_d;
              slt_q       <= slt_d;
              zero_q      <= (res_d == '0);
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
`ifdef ALU_MUL_EN
              product_q   <= '0;
`endif
            end
          end
        end
`ifdef ALU_MUL_EN
        S_MUL: begin
          acc_q    <= acc_step;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == SW'(WIDTH - 1)) begin
            product_q   <= acc_step;
            result_q    <= '0;
            cout_q      <= 1'b0;
            of_q        <= 1'b0;
            slt_q       <= 1'b0;
            zero_q      <= (acc_step == '0);
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign of        = of_q;
  assign zero      = zero_q;
  assign slt       = slt_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: random + directed checks of alu_mc against an arithmetic model.
// Multiply checks follow ALU_MUL_EN.
module tb_alu_mc;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   result;
  logic [2*W-1:0] product;
  logic           cout;
  logic           of;
  logic           zero;
  logic           slt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .product  (product),
    .cout     (cout),
    .of       (of),
    .zero     (zero),
    .slt      (slt)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int o, input int x, input int y,
                                output int res, output int prod,
                                output int c, output int v, output int z,
                                output int s, output int lat);
    int m, h, sx, sy, t;
    m  = 1 << W;
    h  = m / 2;
    sx = (x >= h) ? x - m : x;
    sy = (y >= h) ? y - m : y;
    res = 0; prod = 0; c = 0; v = 0; s = 0; lat = 1;
    case (o)
      0: res = (m - 1) - x;
      1: res = x & y;
      2: res = x | y;
      3: res = (y >= W) ? 0 : (x << y) % m;
      4: res = (y >= W) ? 0 : x >> y;
      5: res = (x & h) | ((y >= W - 1) ? 0 : (x << y) % h);
      6: begin
        t   = (y >= W) ? W - 1 : y;
        res = ((sx >>> t) + m) % m;
      end
      7: begin
        t   = y % W;
        res = ((x << t) | (x >> (W - t))) % m;
      end
      8: begin
        t   = y % W;
        res = ((x >> t) | (x << (W - t))) % m;
      end
      9: begin
        res = (x + y) % m;
        c   = (x + y >= m);
        v   = (sx + sy > h - 1) || (sx + sy < -h);
      end
      10: begin
        res = (x - y + m) % m;
        c   = (x >= y);
        v   = (sx - sy > h - 1) || (sx - sy < -h);
        s   = (sx < sy);
      end
      11: begin
`ifdef ALU_MUL_EN
        prod = x * y;
        lat  = W + 1;
`endif
      end
      default: res = 0;
    endcase
    z = (res == 0) && (prod == 0);
  endfunction

  task automatic run_op(input int o, input int x, input int y);
    int res, prod, c, v, z, s, lat, n, busy_rdy;
    model(o, x, y, res, prod, c, v, z, s, lat);
    @(negedge clk);
    op = 4'(o); a = W'(x); b = W'(y); in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    op = 4'($urandom);
    n = 1;
    busy_rdy = 0;
    while (!out_valid && n < 40) begin
      if (in_ready) busy_rdy = 1;
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("lat op%0d", o), n, lat);
    chk("rdy_busy", busy_rdy, 0);
    chk($sformatf("res op%0d %0h,%0h", o, x, y), result, res);
    chk($sformatf("prod op%0d", o), product, prod);
    chk($sformatf("cout op%0d", o), cout, c);
    chk($sformatf("of op%0d", o), of, v);
    chk($sformatf("zero op%0d", o), zero, z);
    chk($sformatf("slt op%0d", o), slt, s);
    chk("rdy_done", in_ready, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("vld_after_hs", out_valid, 0);
    chk("rdy_after_hs", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] held;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_prod", product, 0);
    chk("rst_flags", {cout, of, zero, slt}, 0);
    @(negedge clk);
    rst = 1'b0;

    // stray out_ready while idle
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_ordy_vld", out_valid, 0);
    chk("idle_ordy_rdy", in_ready, 1);

    run_op(9, 8'h7F, 8'h01);
    run_op(10, 8'h03, 8'h05);
    run_op(10, 8'h80, 8'h01);
    run_op(11, 8'hFF, 8'hFF);
    run_op(11, 8'h00, 8'h37);
    run_op(6, 8'h90, 8'h02);
    run_op(7, 8'h81, 8'h09);
    run_op(3, 8'h01, 8'h08);
    run_op(5, 8'h81, 8'h01);
    run_op(5, 8'hC3, 8'h07);
    run_op(4, 8'hF0, 8'hFF);
    run_op(6, 8'h80, 8'h40);
    run_op(8, 8'h01, 8'h00);
    run_op(14, 8'h12, 8'h34);

    // backpressure: result held, new request ignored
    @(negedge clk);
    op = 4'd9; a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h55; b = 8'h66; op = 4'd1;
    held = result;
    chk("bp_res", held, 8'h30);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_vld", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_stable", result, held);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("bp_rel_rdy", in_ready, 1);
    chk("bp_rel_vld", out_valid, 0);
    @(posedge clk);
    #1;
    chk("bp_no_take", out_valid, 0);

    // reset while busy
`ifdef ALU_MUL_EN
    @(negedge clk);
    op = 4'd11; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
`else
    @(negedge clk);
    op = 4'd9; a = 8'hFF; b = 8'h02; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_vld", out_valid, 0);
    chk("mrst_rdy", in_ready, 1);
    chk("mrst_prod", product, 0);
    chk("mrst_res", result, 0);
    @(negedge clk);
    rst = 1'b0;
    run_op(9, 8'h02, 8'h03);

    for (int i = 0; i < 80; i++)
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
             (i % 4 == 0) ? int'($urandom_range(0, 15))
                          : int'($urandom_range(0, 255)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
